// File: rtl/remove_border_2d_if.sv
// remove_border_2d_if: FIFO-style handshake bundles for the border remover.
// remove_border_2d_rd_if: per-channel read side of a tagged FIFO group.
//   dout  shared data word, empty[N] per-channel status, read[N] per-channel pop
// remove_border_2d_wr_if: write side of the output FIFO.
//   full  back-pressure, write push strobe, din data word
// master = the border remover (actor), slave = the FIFO it talks to.
interface remove_border_2d_rd_if #(
  parameter int W = 19,
  parameter int N = 2
);
  logic [W-1:0] dout;
  logic [N-1:0] empty;
  logic [N-1:0] read;
  modport master (input dout, input empty, output read);
  modport slave (output dout, output empty, input read);
endinterface

interface remove_border_2d_wr_if #(
  parameter int W = 19
);
  logic         full;
  logic         write;
  logic [W-1:0] din;
  modport master (input full, output write, output din);
  modport slave (output full, input write, input din);
endinterface

// File: rtl/remove_border_2d.sv
// remove_border_2d: multi-flux 2D border remover, forwards the inner pels of each E x E block.
// Ports: clk, rst (async, active-high);
//   write_port_out_pel  output pels {tag, pel}
//   read_port_in_pel    input pels, empty/read per flux
//   read_port_ext_size  extended block size E per flux
// Define REMOVE_BORDER_2D_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module remove_border_2d #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 18,
  parameter int SIZE_WIDTH = 7,
  parameter int BORDER_L   = 3,
  parameter int BORDER_R   = 4,
  parameter int BORDER_T   = 3,
  parameter int BORDER_B   = 4,
  parameter int TAG_WIDTH  = FLUX > 1 ? $clog2(FLUX) : 1
) (
  input logic                   clk,
  input logic                   rst,
  remove_border_2d_wr_if.master write_port_out_pel,
  remove_border_2d_rd_if.master read_port_in_pel,
  remove_border_2d_rd_if.master read_port_ext_size
);
  localparam int CW = SIZE_WIDTH + 1;
  localparam logic [CW-1:0] BL = CW'(BORDER_L);
  localparam logic [CW-1:0] BR = CW'(BORDER_R);
  localparam logic [CW-1:0] BT = CW'(BORDER_T);
  localparam logic [CW-1:0] BB = CW'(BORDER_B);

  typedef enum logic {IDLE, STREAM} st_t;

  logic [FLUX-1:0]      idle, keep, elig, gnt;
  logic [TAG_WIDTH-1:0] sel;
  logic                 any;

  for (genvar g = 0; g < FLUX; g++) begin : g_flux
    st_t                  st_q, st_d;
    logic [SIZE_WIDTH-1:0] row_q, row_d, col_q, col_d, ext_q, ext_d, em1, tok;
    logic [CW-1:0]         r, c, e;
    logic                  col_end;
    // One extra bit so border sums never wrap against E.
    assign r       = {1'b0, row_q};
    assign c       = {1'b0, col_q};
    assign e       = {1'b0, ext_q};
    assign em1     = ext_q - 1'b1;
    assign tok     = read_port_ext_size.dout[SIZE_WIDTH-1:0];
    assign col_end = col_q == em1;
    assign idle[g] = st_q == IDLE;
    assign keep[g] = r >= BT && r + BB < e && c >= BL && c + BR < e;
    // Dropped pels are consumed regardless of output back-pressure.
    assign elig[g] = idle[g] ? ~read_port_ext_size.empty[g]
                             : ~read_port_in_pel.empty[g] & (~keep[g] | ~write_port_out_pel.full);
    always_comb begin
      st_d  = st_q;
      row_d = row_q;
      col_d = col_q;
      ext_d = ext_q;
      if (gnt[g] && idle[g]) begin
        ext_d = tok;
        st_d  = tok == '0 ? IDLE : STREAM;
      end else if (gnt[g]) begin
        col_d = col_end ? '0 : col_q + 1'b1;
        row_d = col_end ? row_q + 1'b1 : row_q;
        if (col_end && row_q == em1) begin
          st_d  = IDLE;
          row_d = '0;
        end
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= IDLE;
        row_q <= '0;
        col_q <= '0;
        ext_q <= '0;
      end else begin
        st_q  <= st_d;
        row_q <= row_d;
        col_q <= col_d;
        ext_q <= ext_d;
      end
    end
  end

`ifdef REMOVE_BORDER_2D_RR_EN
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic                 hit;
  // Search starts one past the last served flux.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= FLUX; k++) begin
      if (!hit && elig[(int'(ptr_q) + k) % FLUX]) begin
        sel = TAG_WIDTH'((int'(ptr_q) + k) % FLUX);
        hit = 1'b1;
      end
    end
  end
  assign ptr_d = any ? sel : ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= TAG_WIDTH'(FLUX - 1);
    else ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = FLUX - 1; i >= 0; i--) if (elig[i]) sel = TAG_WIDTH'(i);
  end
`endif

  // Reset gates the handshake so nothing is popped or pushed while it is held.
  assign any = |elig & ~rst;
  assign gnt = any ? FLUX'(1) << sel : '0;

  assign read_port_ext_size.read = gnt & idle;
  assign read_port_in_pel.read   = gnt & ~idle;
  assign write_port_out_pel.write = any & ~idle[sel] & keep[sel];
  assign write_port_out_pel.din   = {sel, read_port_in_pel.dout[DATA_WIDTH-1:0]};
endmodule

// File: tb/tb_remove_border_2d.sv
// tb_remove_border_2d: table-driven directed checks of the 2D border remover.
module tb_remove_border_2d;
  localparam int FLUX = 2, DW = 18, SW = 7, TW = 1;
  localparam int BL = 3, BR = 4, BT = 3, BB = 4;

  typedef struct {
    int e0; int e1; int en1; int full_until;
    int rd0; int rd1; int wr0; int wr1; int first0; int last0;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  remove_border_2d_rd_if #(.W(DW + TW), .N(FLUX)) pel_if();
  remove_border_2d_rd_if #(.W(SW + TW), .N(FLUX)) ext_if();
  remove_border_2d_wr_if #(.W(DW + TW)) out_if();

  remove_border_2d #(.FLUX(FLUX), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk(clk),
    .rst(rst),
    .write_port_out_pel(out_if),
    .read_port_in_pel(pel_if),
    .read_port_ext_size(ext_if)
  );

  int pel_cnt[FLUX], pel_limit[FLUX], ext_taken[FLUX], ext_arm[FLUX], ext_val[FLUX];
  int rd_multi;
  logic [TW-1:0] rd_tags[$];
  logic [DW+TW-1:0] wr_q[$];
  int n_vec = 0, n_err = 0;
  vec_t vecs[6];

  always_comb begin
    pel_if.empty = '1;
    ext_if.empty = '1;
    for (int f = 0; f < FLUX; f++) begin
      pel_if.empty[f] = pel_cnt[f] >= pel_limit[f];
      ext_if.empty[f] = ext_taken[f] >= ext_arm[f];
    end
  end

  // Upstream muxes its data onto the shared dout by the read strobe; size tag bits are deliberately wrong.
  always_comb begin
    pel_if.dout = {1'b0, DW'(pel_cnt[0])};
    if (pel_if.read[1]) pel_if.dout = {1'b1, DW'(1000 + pel_cnt[1])};
    ext_if.dout = {1'b1, SW'(ext_val[0])};
    if (ext_if.read[1]) ext_if.dout = {1'b0, SW'(ext_val[1])};
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int f = 0; f < FLUX; f++) begin
        pel_cnt[f]   <= 0;
        ext_taken[f] <= 0;
      end
      rd_multi <= 0;
      rd_tags.delete();
      wr_q.delete();
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (pel_if.read[f]) begin
          pel_cnt[f] <= pel_cnt[f] + 1;
          rd_tags.push_back(TW'(f));
        end
        if (ext_if.read[f]) ext_taken[f] <= ext_taken[f] + 1;
      end
      if ($countones({pel_if.read, ext_if.read}) > 1) rd_multi <= rd_multi + 1;
      if (out_if.write) wr_q.push_back(out_if.din);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, done, nw[FLUX], bad, first0, last0, e, wd, k, f, exp_val, tag_bad;
    rst = 1'b1;
    clr = 1'b1;
    out_if.full = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      ext_arm[i] = 0;
      pel_limit[i] = 0;
    end
    ext_val[0] = v.e0;
    ext_val[1] = v.e1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    ext_arm[0] = 1;
    pel_limit[0] = v.e0 * v.e0;
    if (v.en1 != 0) begin
      ext_arm[1] = 1;
      pel_limit[1] = v.e1 * v.e1;
    end
    out_if.full = v.full_until > 0;
    #1;
    check("rst_read", int'({pel_if.read, ext_if.read}), 0);
    check("rst_write", int'(out_if.write), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("token_read", int'(ext_if.read[0]), 1);
    cyc = 0;
    done = 0;
    while (done == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      out_if.full = cyc < v.full_until;
      if (v.full_until > 0 && cyc == 60) begin
        check("stall_reads", pel_cnt[0], 39);
        check("stall_writes", wr_q.size(), 0);
      end
      done = int'(ext_taken[0] == ext_arm[0] && pel_cnt[0] == pel_limit[0] &&
                  ext_taken[1] == ext_arm[1] && pel_cnt[1] == pel_limit[1]);
    end
    check("timeout", done, 1);
    pel_limit[0] = pel_limit[0] + 1;
    repeat (3) @(negedge clk);
    check("reads0_then_idle", pel_cnt[0], v.rd0);
    check("reads1", pel_cnt[1], v.rd1);
    check("tokens0", ext_taken[0], 1);
    nw = '{0, 0};
    bad = 0;
    first0 = -1;
    last0 = -1;
    foreach (wr_q[i]) begin
      f = int'(wr_q[i][DW]);
      e = f == 0 ? v.e0 : v.e1;
      wd = e - BL - BR;
      k = nw[f];
      exp_val = wd > 0 ? f * 1000 + (BT + k / wd) * e + BL + k % wd : -1;
      if (int'(wr_q[i][DW-1:0]) != exp_val) bad++;
      if (f == 0) begin
        if (first0 < 0) first0 = int'(wr_q[i][DW-1:0]);
        last0 = int'(wr_q[i][DW-1:0]);
      end
      nw[f]++;
    end
    check("writes0", nw[0], v.wr0);
    check("writes1", nw[1], v.wr1);
    check("write_seq", bad, 0);
    if (v.wr0 > 0) begin
      check("first_pel0", first0, v.first0);
      check("last_pel0", last0, v.last0);
    end
    check("multi_read", rd_multi, 0);
    if (v.en1 != 0) begin
      tag_bad = 0;
      foreach (rd_tags[i]) begin
`ifdef REMOVE_BORDER_2D_RR_EN
        if (int'(rd_tags[i]) != i % 2) tag_bad++;
`else
        if (int'(rd_tags[i]) != (i < 144 ? 0 : 1)) tag_bad++;
`endif
      end
      check("tag_order", tag_bad, 0);
    end
  endtask

  initial begin
    int t;
    out_if.full = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      ext_arm[i] = 0;
      pel_limit[i] = 0;
      ext_val[i] = 0;
    end
    //            e0  e1 en1 full rd0  rd1 wr0 wr1 first last
    vecs[0] = '{12,  0, 0,   0, 144,   0, 25,  0, 39, 91};
    vecs[1] = '{12,  0, 0,  81, 144,   0, 25,  0, 39, 91};
    vecs[2] = '{ 7,  0, 0,   0,  49,   0,  0,  0, -1, -1};
    vecs[3] = '{ 0,  0, 0,   0,   0,   0,  0,  0, -1, -1};
    vecs[4] = '{ 8,  0, 0,   0,  64,   0,  1,  0, 27, 27};
    vecs[5] = '{12, 12, 1,   0, 144, 144, 25, 25, 39, 91};
    foreach (vecs[i]) run_vec(vecs[i]);

    rst = 1'b1;
    clr = 1'b1;
    pel_limit[1] = 0;
    ext_arm[1] = 0;
    ext_arm[0] = 0;
    ext_val[0] = 12;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    ext_arm[0] = 1;
    pel_limit[0] = 144;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (pel_cnt[0] != 51 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("reach_pel51", pel_cnt[0], 51);
    #2;
    check("pre_reset_write", int'(out_if.write), 1);
    rst = 1'b1;
    #1;
    check("async_rst_read", int'({pel_if.read, ext_if.read}), 0);
    check("async_rst_write", int'(out_if.write), 0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
